// File: rtl/uart_pkg.sv
// Shared definitions for the UART block: ASCII control characters, formatter
// FSM encoding and the nibble-to-ASCII helper.
package uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Bits per serial frame on the transmitter side (start + 8 data + stop).
  localparam int SERIAL_WCNT = 10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HEX  = 3'd1,
    ST_CR   = 3'd2,
    ST_LF   = 3'd3,
    ST_WACK = 3'd4
  } fmt_state_t;

  function automatic logic [7:0] hex2ascii(input logic [3:0] n);
    logic [7:0] wide;
    wide = {4'h0, n};
    if (n < 4'd10) return 8'h30 + wide;
    else           return 8'h41 + (wide - 8'd10);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO; dout shows the head entry whenever the FIFO is not empty.
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_hexfmt.sv
// Renders buffered words as uppercase hex plus CR LF, one character per
// transmitter handshake.
module uart_hexfmt
  import uart_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int NIBBLES = 8
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   in_valid,
  input  logic [4*NIBBLES-1:0]   in_data,
  output logic                   in_ready,
  output logic                   tx_we,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  output logic                   busy
);

  localparam int WIDTH = 4 * NIBBLES;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int LW    = $clog2(NIBBLES + 1);

  fmt_state_t       state, state_n;
  fmt_state_t       ret_state, ret_state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [LW-1:0]    chars_left, chars_left_n;
  logic             tx_we_n;
  logic [7:0]       tx_data_n;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] fifo_dout;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign busy     = (state != ST_IDLE) || !fifo_empty;

  uart_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clk   (clk),
    .rst_  (rst_),
    .push  (push),
    .pop   (pop),
    .din   (in_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= ST_IDLE;
    else       state <= state_n;
  end

  // WACK waits for tx_ready to drop so the transmitter has latched the byte.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (fifo_count != '0) state_n = ST_HEX;
      ST_HEX,
      ST_CR,
      ST_LF:   if (tx_ready) state_n = ST_WACK;
      ST_WACK: if (!tx_ready) state_n = ret_state;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    pop          = 1'b0;
    shreg_n      = shreg;
    chars_left_n = chars_left;
    ret_state_n  = ret_state;
    tx_we_n      = 1'b0;
    tx_data_n    = tx_data;
    case (state)
      ST_IDLE: begin
        if (fifo_count != '0) begin
          pop          = 1'b1;
          shreg_n      = fifo_dout;
          chars_left_n = LW'(NIBBLES);
        end
      end
      ST_HEX: begin
        if (tx_ready) begin
          tx_we_n      = 1'b1;
          tx_data_n    = hex2ascii(shreg[WIDTH-1 -: 4]);
          shreg_n      = {shreg[WIDTH-5:0], 4'h0};
          chars_left_n = chars_left - LW'(1);
          ret_state_n  = (chars_left > LW'(1)) ? ST_HEX : ST_CR;
        end
      end
      ST_CR: begin
        if (tx_ready) begin
          tx_we_n     = 1'b1;
          tx_data_n   = ASCII_CR;
          ret_state_n = ST_LF;
        end
      end
      ST_LF: begin
        if (tx_ready) begin
          tx_we_n     = 1'b1;
          tx_data_n   = ASCII_LF;
          ret_state_n = ST_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ret_state  <= ST_IDLE;
      shreg      <= '0;
      chars_left <= '0;
      tx_we      <= 1'b0;
      tx_data    <= 8'h00;
    end else begin
      ret_state  <= ret_state_n;
      shreg      <= shreg_n;
      chars_left <= chars_left_n;
      tx_we      <= tx_we_n;
      tx_data    <= tx_data_n;
    end
  end

endmodule
